// File: rtl/alu_wb_stage_pkg.sv
// Shared opcode, condition-code, state and flag-index definitions for the ALU and write-back stage.
// The ALU and fetch stage use these constants as well, so keep encodings stable.
package simple_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_CMP  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_RSV7 = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_IN   = 4'b1100;
  localparam logic [3:0] OP_OUT  = 4'b1101;
  localparam logic [3:0] OP_RSVE = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    OUT_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  // Ops whose ALU result is committed to the register file.
  function automatic logic is_wb_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV,
      OP_SLL, OP_SRL, OP_ROL, OP_SRA: is_wb_op = 1'b1;
      default:                        is_wb_op = 1'b0;
    endcase
  endfunction

  function automatic logic updates_flags(input logic [3:0] op);
    updates_flags = is_wb_op(op) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_wb_stage_if.sv
// Bundle of the stage's upstream handshake, register-file port, branch query and OUT port.
// slave is the stage's view; master is the surrounding pipeline / environment.
interface alu_wb_if #(
  parameter int REG_AW = 3,
  parameter int DW     = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [DW-1:0]     alu_out;
  logic [3:0]        alu_szcv;
  logic [REG_AW-1:0] rd;
  logic [DW-1:0]     opnd;
  logic [DW-1:0]     in_port;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [3:0]        szcv_q;
  logic [2:0]        cond;
  logic              taken;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              halted;

  modport slave (
    input  in_valid, op, alu_out, alu_szcv, rd, opnd, in_port, cond, out_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata, szcv_q, taken, out_valid, out_data, halted
  );

  modport master (
    output in_valid, op, alu_out, alu_szcv, rd, opnd, in_port, cond, out_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata, szcv_q, taken, out_valid, out_data, halted
  );
endinterface

// File: rtl/alu_wb_stage_flag_cond_eval.sv
// Combinational branch-condition evaluator over an SZCV flag word; zero latency, no handshake.
module flag_cond_eval
  import simple_pkg::*;
(
  input  logic [3:0] szcv_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);
  logic s_xor_v;
  logic unused_carry;

  assign s_xor_v      = szcv_i[FLAG_S] ^ szcv_i[FLAG_V];
  assign unused_carry = szcv_i[FLAG_C];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_BE:   taken_o = szcv_i[FLAG_Z];
      CC_BLT:  taken_o = s_xor_v;
      CC_BLE:  taken_o = szcv_i[FLAG_Z] | s_xor_v;
      CC_BNE:  taken_o = ~szcv_i[FLAG_Z];
      default: taken_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_wb_stage.sv
// Execute/write-back stage: commits results, holds SZCV flags, drives OUT and owns HALT.
// Writes and flags land 1 cycle after accept; in_ready is low while an OUT is pending or halted.
module alu_wb_stage
  import simple_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int DW     = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_wb_if.slave bus
);
  state_e            state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]     rf_wdata_q, rf_wdata_d;
  logic [3:0]        flags_q, flags_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              accept;
  logic              taken;

  assign accept = bus.in_valid && (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    flags_d    = flags_q;
    out_data_d = out_data_q;

    case (state_q)
      RUN: begin
        if (accept) begin
          if (is_wb_op(bus.op)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = bus.rd;
            rf_wdata_d = bus.alu_out;
          end
          if (updates_flags(bus.op)) begin
            flags_d = bus.alu_szcv;
          end
          case (bus.op)
            OP_IN: begin
              rf_we_d    = 1'b1;
              rf_waddr_d = bus.rd;
              rf_wdata_d = bus.in_port;
            end
            OP_OUT: begin
              out_data_d = bus.opnd;
              state_d    = OUT_WAIT;
            end
            OP_HALT: state_d = HALTED;
            default: ;
          endcase
        end
      end
      // out_data stays registered so it is stable for the whole wait.
      OUT_WAIT: begin
        if (bus.out_ready) begin
          state_d = RUN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      flags_q    <= 4'b0000;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      flags_q    <= flags_d;
      out_data_q <= out_data_d;
    end
  end

  flag_cond_eval u_cond (
    .szcv_i  (flags_q),
    .cond_i  (bus.cond),
    .taken_o (taken)
  );

  assign bus.in_ready  = (state_q == RUN);
  assign bus.out_valid = (state_q == OUT_WAIT);
  assign bus.halted    = (state_q == HALTED);
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.szcv_q    = flags_q;
  assign bus.out_data  = out_data_q;
  assign bus.taken     = taken;
endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: back-to-back vector table through a scoreboard, then OUT/HALT/reset sequences.
module tb_alu_wb_stage;
  import simple_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_wb_if #(.REG_AW(3), .DW(16)) bus ();

  alu_wb_stage #(.REG_AW(3), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] alu_out;
    logic [3:0]  alu_szcv;
    logic [2:0]  rd;
    logic [15:0] in_port;
    logic [2:0]  cond;
    logic        exp_we;
    logic [2:0]  exp_waddr;
    logic [15:0] exp_wdata;
    logic [3:0]  exp_szcv;
    logic        exp_taken;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];
  vec_t sb [$];
  vec_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] alu_out, input logic [3:0] szcv,
                       input logic [2:0] rd, input logic [15:0] opnd, input logic [15:0] in_port);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.alu_out  = alu_out;
    bus.alu_szcv = szcv;
    bus.rd       = rd;
    bus.opnd     = opnd;
    bus.in_port  = in_port;
  endtask

  task automatic drive_vec(input vec_t v);
    drive(v.op, v.alu_out, v.alu_szcv, v.rd, 16'h0000, v.in_port);
  endtask

  initial begin
    //           op       alu_out   szcv     rd    in_port   cond    we    waddr exp_wdata exp_szcv taken
    vecs[0]  = '{OP_ADD,  16'h1234, 4'b0000, 3'd3, 16'h0000, CC_BE,  1'b1, 3'd3, 16'h1234, 4'b0000, 1'b0};
    vecs[1]  = '{OP_CMP,  16'hAAAA, 4'b1001, 3'd5, 16'h0000, CC_BLT, 1'b0, 3'd0, 16'h0000, 4'b1001, 1'b0};
    vecs[2]  = '{OP_CMP,  16'h0000, 4'b0100, 3'd5, 16'h0000, CC_BE,  1'b0, 3'd0, 16'h0000, 4'b0100, 1'b1};
    vecs[3]  = '{OP_IN,   16'hDEAD, 4'b1111, 3'd7, 16'h00FF, CC_BLE, 1'b1, 3'd7, 16'h00FF, 4'b0100, 1'b1};
    vecs[4]  = '{OP_SUB,  16'h0F0F, 4'b1000, 3'd1, 16'h0000, CC_BLT, 1'b1, 3'd1, 16'h0F0F, 4'b1000, 1'b1};
    vecs[5]  = '{OP_RSV7, 16'h5555, 4'b0110, 3'd2, 16'h0000, CC_BNE, 1'b0, 3'd0, 16'h0000, 4'b1000, 1'b1};
    vecs[6]  = '{OP_XOR,  16'h0000, 4'b0100, 3'd0, 16'h0000, CC_BNE, 1'b1, 3'd0, 16'h0000, 4'b0100, 1'b0};
    vecs[7]  = '{OP_MOV,  16'h8001, 4'b0011, 3'd6, 16'h0000, 3'b100, 1'b1, 3'd6, 16'h8001, 4'b0011, 1'b0};
    vecs[8]  = '{OP_CMP,  16'h0000, 4'b0000, 3'd2, 16'h0000, CC_BNE, 1'b0, 3'd0, 16'h0000, 4'b0000, 1'b1};
    vecs[9]  = '{OP_RSVE, 16'h7777, 4'b1111, 3'd3, 16'h0000, CC_BNE, 1'b0, 3'd0, 16'h0000, 4'b0000, 1'b1};
    vecs[10] = '{OP_SRA,  16'hC000, 4'b1000, 3'd4, 16'h0000, CC_BLE, 1'b1, 3'd4, 16'hC000, 4'b1000, 1'b1};
    vecs[11] = '{OP_SLL,  16'h0001, 4'b0001, 3'd5, 16'h0000, 3'b111, 1'b1, 3'd5, 16'h0001, 4'b0001, 1'b0};
    vecs[12] = '{OP_OR,   16'h00F0, 4'b0000, 3'd2, 16'h0000, CC_BLE, 1'b1, 3'd2, 16'h00F0, 4'b0000, 1'b0};
    vecs[13] = '{OP_SRL,  16'h4000, 4'b0010, 3'd1, 16'h0000, CC_BE,  1'b1, 3'd1, 16'h4000, 4'b0010, 1'b0};
    vecs[14] = '{OP_ROL,  16'h0003, 4'b0101, 3'd3, 16'h0000, CC_BLT, 1'b1, 3'd3, 16'h0003, 4'b0101, 1'b1};

    bus.in_valid = 1'b0; bus.op = 4'h0; bus.alu_out = '0; bus.alu_szcv = '0; bus.rd = '0;
    bus.opnd = '0; bus.in_port = '0; bus.cond = CC_BE; bus.out_ready = 1'b0;

    #2;
    chk("reset in_ready",  bus.in_ready, 1);
    chk("reset rf_we",     bus.rf_we, 0);
    chk("reset rf_waddr",  bus.rf_waddr, 0);
    chk("reset rf_wdata",  bus.rf_wdata, 0);
    chk("reset szcv_q",    bus.szcv_q, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data",  bus.out_data, 0);
    chk("reset halted",    bus.halted, 0);
    chk("reset taken",     bus.taken, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: a new vector is presented every cycle while the previous one is checked.
    drive_vec(vecs[0]);
    sb.push_back(vecs[0]);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      bus.cond = e.cond;
      if (i + 1 < NVEC) begin
        drive_vec(vecs[i + 1]);
        sb.push_back(vecs[i + 1]);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      chk($sformatf("v%0d rf_we", i), bus.rf_we, e.exp_we);
      if (e.exp_we) begin
        chk($sformatf("v%0d rf_waddr", i), bus.rf_waddr, e.exp_waddr);
        chk($sformatf("v%0d rf_wdata", i), bus.rf_wdata, e.exp_wdata);
      end
      chk($sformatf("v%0d szcv_q", i), bus.szcv_q, e.exp_szcv);
      chk($sformatf("v%0d taken", i), bus.taken, e.exp_taken);
      chk($sformatf("v%0d in_ready", i), bus.in_ready, 1);
    end

    @(negedge clk);
    chk("idle rf_we", bus.rf_we, 0);
    chk("idle szcv_q", bus.szcv_q, 4'b0101);

    // out_ready before any OUT has no effect.
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("early out_ready out_valid", bus.out_valid, 0);
    chk("early out_ready in_ready", bus.in_ready, 1);

    bus.out_ready = 1'b0;
    drive(OP_OUT, 16'h0000, 4'b1111, 3'd0, 16'hBEEF, 16'h0000);
    @(negedge clk);
    drive(OP_ADD, 16'h1111, 4'b1010, 3'd1, 16'h0000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("outwait%0d out_valid", k), bus.out_valid, 1);
      chk($sformatf("outwait%0d out_data", k), bus.out_data, 16'hBEEF);
      chk($sformatf("outwait%0d in_ready", k), bus.in_ready, 0);
      chk($sformatf("outwait%0d rf_we", k), bus.rf_we, 0);
      chk($sformatf("outwait%0d szcv_q", k), bus.szcv_q, 4'b0101);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out done out_valid", bus.out_valid, 0);
    chk("out done in_ready", bus.in_ready, 1);
    chk("out done rf_we", bus.rf_we, 0);

    // Reset while an OUT is pending drops it.
    drive(OP_OUT, 16'h0000, 4'b0000, 3'd0, 16'h1357, 16'h0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("out2 out_valid", bus.out_valid, 1);
    chk("out2 out_data", bus.out_data, 16'h1357);
    #2 rst_n = 1'b0;
    #1;
    chk("out rst out_valid", bus.out_valid, 0);
    chk("out rst out_data", bus.out_data, 0);
    chk("out rst in_ready", bus.in_ready, 1);
    chk("out rst szcv_q", bus.szcv_q, 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(OP_ADD, 16'h2222, 4'b1010, 3'd2, 16'h0000, 16'h0000);
    @(negedge clk);
    drive(OP_HALT, 16'h0000, 4'b0000, 3'd0, 16'h0000, 16'h0000);
    chk("pre-halt rf_wdata", bus.rf_wdata, 16'h2222);
    chk("pre-halt szcv_q", bus.szcv_q, 4'b1010);
    @(negedge clk);
    drive(OP_ADD, 16'h9999, 4'b0000, 3'd5, 16'h0000, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("halt%0d halted", k), bus.halted, 1);
      chk($sformatf("halt%0d in_ready", k), bus.in_ready, 0);
      chk($sformatf("halt%0d rf_we", k), bus.rf_we, 0);
      chk($sformatf("halt%0d szcv_q", k), bus.szcv_q, 4'b1010);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("halt rst halted", bus.halted, 0);
    chk("halt rst szcv_q", bus.szcv_q, 0);
    chk("halt rst in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst rf_we", bus.rf_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
